// File: rtl/jtag_dr_bank.sv
// Virtual-JTAG data-register bank: NUM_REGS consecutive IR codes share one shift
// register with capture readback, TDO mux and per-register update strobes.
module jtag_dr_bank #(
    parameter int                    DR_WIDTH  = 15,
    parameter int                    NUM_REGS  = 4,
    parameter int                    IR_WIDTH  = 3,
    parameter int                    IR_BASE   = 4,
    parameter logic [DR_WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         tck,
    input  logic                         aclr,
    input  logic                         tdi,
    input  logic [IR_WIDTH-1:0]          ir_in,
    input  logic                         v_cdr,
    input  logic                         v_sdr,
    input  logic                         v_udr,
    output logic                         tdo,
    output logic [NUM_REGS*DR_WIDTH-1:0] dr_out,
    output logic [NUM_REGS-1:0]          upd_strobe,
    output logic                         sel_valid
);

    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IR_WIDTH:0]   BASE_EXT = (IR_WIDTH+1)'(IR_BASE);
    localparam logic [IR_WIDTH:0]   TOP_EXT  = (IR_WIDTH+1)'(IR_BASE + NUM_REGS);
    localparam logic [IR_WIDTH-1:0] BASE_IR  = IR_WIDTH'(IR_BASE);

    logic [DR_WIDTH-1:0] regs [NUM_REGS];
    logic [DR_WIDTH-1:0] shreg;
    logic                bypass;
    logic                udr_d;
    logic [IR_WIDTH:0]   ir_ext;
    logic [SEL_W-1:0]    sel;
    logic                upd_event;

    assign ir_ext    = {1'b0, ir_in};
    assign sel_valid = (ir_ext >= BASE_EXT) && (ir_ext < TOP_EXT);
    assign sel       = SEL_W'(ir_in - BASE_IR);
    assign upd_event = v_udr && !udr_d;
    assign tdo       = sel_valid ? shreg[0] : bypass;

    always_ff @(posedge tck) begin
        if (aclr) begin
            shreg      <= '0;
            bypass     <= 1'b0;
            udr_d      <= 1'b0;
            upd_strobe <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
        end else begin
            udr_d <= v_udr;
            if (v_cdr) begin
                if (sel_valid) shreg <= regs[sel];
                bypass <= 1'b0;
            end else if (v_sdr) begin
                bypass <= tdi;
                if (sel_valid) shreg <= {tdi, shreg[DR_WIDTH-1:1]};
            end
            // Update commits the pre-edge shreg, independent of any capture/shift this edge.
            if (upd_event && sel_valid) begin
                regs[sel]  <= shreg;
                upd_strobe <= NUM_REGS'(1) << sel;
            end else begin
                upd_strobe <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign dr_out[k*DR_WIDTH +: DR_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Bench for jtag_dr_bank: directed scenarios plus random JTAG traffic, checked
// every cycle against a behavioural register-bank model.
module tb_jtag_dr_bank;

    localparam int DW = 15;
    localparam int NR = 4;
    localparam logic [DW-1:0] RV = 15'h0005;

    logic          tck = 1'b0;
    logic          aclr = 1'b0, tdi = 1'b0, v_cdr = 1'b0, v_sdr = 1'b0, v_udr = 1'b0;
    logic [2:0]    ir_in = 3'd0;
    logic          tdo;
    logic [NR*DW-1:0] dr_out;
    logic [NR-1:0] upd_strobe;
    logic          sel_valid;

    int checks = 0;
    int errors = 0;

    jtag_dr_bank #(.DR_WIDTH(DW), .NUM_REGS(NR), .IR_WIDTH(3), .IR_BASE(4), .RESET_VAL(RV)) dut (
        .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in), .v_cdr(v_cdr), .v_sdr(v_sdr),
        .v_udr(v_udr), .tdo(tdo), .dr_out(dr_out), .upd_strobe(upd_strobe), .sel_valid(sel_valid)
    );

    always #5 tck = ~tck;

    // behavioural model
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_sh;
    logic          m_byp, m_udrd;
    logic [NR-1:0] m_stb;
    logic [2:0]    m_ir;
    bit            model_valid = 0;

    function automatic bit valid_ir(logic [2:0] ir);
        return (ir >= 3'd4);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_dr();
        logic [NR*DW-1:0] v;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = m_regs[k];
        return v;
    endfunction

    always @(negedge tck) begin
        if (model_valid) begin
            chk("sel_valid", 64'(sel_valid), 64'(valid_ir(m_ir)));
            chk("tdo", 64'(tdo), 64'(valid_ir(m_ir) ? m_sh[0] : m_byp));
            chk("dr_out", 64'(dr_out), 64'(exp_dr()));
            chk("upd_strobe", 64'(upd_strobe), 64'(m_stb));
        end
    end

    task automatic step(input logic a, input logic c, input logic s, input logic u,
                        input logic d, input logic [2:0] ir);
        aclr = a; v_cdr = c; v_sdr = s; v_udr = u; tdi = d; ir_in = ir;
        @(posedge tck);
        m_ir = ir;
        if (a) begin
            m_sh = '0; m_byp = 0; m_udrd = 0; m_stb = '0;
            for (int k = 0; k < NR; k++) m_regs[k] = RV;
        end else begin
            int idx;
            logic [DW-1:0] old_sh;
            idx = int'(ir) - 4;
            old_sh = m_sh;
            if (c) begin
                if (valid_ir(ir)) m_sh = m_regs[idx];
                m_byp = 0;
            end else if (s) begin
                m_byp = d;
                if (valid_ir(ir)) m_sh = (old_sh >> 1) | (DW'(d) << (DW-1));
            end
            m_stb = '0;
            if (u && !m_udrd && valid_ir(ir)) begin
                m_regs[idx] = old_sh;
                m_stb = NR'(1 << idx);
            end
            m_udrd = u;
        end
        model_valid = 1;
        @(negedge tck);
        #1;
    endtask

    logic [DW-1:0] pat, rb;
    logic [3:0]    bseq;
    logic [NR*DW-1:0] snap;
    int            nstb;

    initial begin
        // reset
        step(1, 0, 0, 0, 0, 3'd7);
        step(1, 0, 0, 0, 0, 3'd7);
        chk("rst_field0", 64'(dr_out[0 +: DW]), 64'h0005);
        chk("rst_field3", 64'(dr_out[3*DW +: DW]), 64'h0005);
        chk("rst_strobe", 64'(upd_strobe), 64'h0);
        chk("rst_tdo", 64'(tdo), 64'h0);

        // write reg 3
        pat = 15'h2A5C;
        step(0, 1, 0, 0, 0, 3'd7);
        for (int i = 0; i < DW; i++) step(0, 0, 1, 0, pat[i], 3'd7);
        step(0, 0, 0, 1, 0, 3'd7);
        chk("wr_strobe", 64'(upd_strobe), 64'h8);
        chk("wr_field3", 64'(dr_out[3*DW +: DW]), 64'h2A5C);
        chk("wr_field1", 64'(dr_out[1*DW +: DW]), 64'h0005);
        step(0, 0, 0, 0, 0, 3'd7);
        chk("wr_strobe_drop", 64'(upd_strobe), 64'h0);

        // readback
        step(0, 1, 0, 0, 0, 3'd7);
        for (int i = 0; i < DW; i++) begin
            rb[i] = tdo;
            step(0, 0, 1, 0, 1'b0, 3'd7);
        end
        chk("readback", 64'(rb), 64'h2A5C);

        // bypass
        snap = dr_out;
        step(0, 1, 0, 0, 0, 3'd1);
        bseq = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            rb[i] = tdo;
            step(0, 0, 1, 0, bseq[i], 3'd1);
        end
        chk("bypass_tdo", 64'(rb[3:0]), 64'b1010);
        step(0, 0, 0, 1, 0, 3'd1);
        chk("bypass_strobe", 64'(upd_strobe), 64'h0);
        step(0, 0, 0, 0, 0, 3'd1);
        chk("bypass_dr", 64'(dr_out), 64'(snap));

        // level update on reg 0
        nstb = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 3'd4);
            if (upd_strobe != 0) nstb++;
            if (i == 0) chk("lvl_strobe", 64'(upd_strobe), 64'h1);
        end
        step(0, 0, 0, 0, 0, 3'd4);
        chk("lvl_count", 64'(nstb), 64'd1);

        // mid-operation reset on reg 2
        step(0, 1, 0, 0, 0, 3'd6);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1'b1, 3'd6);
        step(1, 0, 1, 1, 1, 3'd6);
        chk("mrst_strobe", 64'(upd_strobe), 64'h0);
        step(1, 0, 0, 1, 0, 3'd6);
        chk("mrst_field2", 64'(dr_out[2*DW +: DW]), 64'h0005);
        chk("mrst_shreg0", 64'(tdo), 64'h0);

        // priority: capture beats shift, bypass cleared
        step(0, 0, 1, 0, 1, 3'd1);
        chk("prio_byp_set", 64'(tdo), 64'h1);
        step(0, 1, 1, 0, 1, 3'd5);
        chk("prio_tdo", 64'(tdo), 64'h1);
        step(0, 0, 0, 0, 0, 3'd1);
        chk("prio_bypass", 64'(tdo), 64'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0),
                 1'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
